// File: rtl/cordic_phase_feeder.sv
// Phase-sweep feeder for a cosine engine: wraps a phase accumulator into [-PI, PI] and issues one angle at a time.
// Results are queued in a show-ahead FIFO; define CORDIC_FEED_TIMEOUT_EN to add a 64-cycle WAIT watchdog.
module cordic_phase_feeder #(
    parameter int Q     = 4,
    parameter int F     = 23,
    parameter int DEPTH = 4,
    localparam int W    = Q + F
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] phase_init,
    input  logic [W-1:0] phase_inc,
    output logic         cordic_start,
    output logic [W-1:0] cordic_theta,
    input  logic [W-1:0] cordic_cos,
    input  logic         cordic_done,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         fifo_empty,
    output logic         fifo_full,
    output logic         overflow,
    input  logic         ovf_clr,
    output logic         timeout
);

    localparam logic [W-1:0] PI     = W'(27'h1921FB5);
    localparam logic [W-1:0] TWO_PI = W'(27'h3243F6A);
    localparam logic signed [W:0] PI_X     = {1'b0, PI};
    localparam logic signed [W:0] TWO_PI_X = {1'b0, TWO_PI};
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   phase;
    logic [W-1:0]   phase_next;
    logic signed [W:0] inc_sat;
    logic signed [W:0] sum;
    logic signed [W:0] wrapped;
    logic           push;
    logic           pop;
    logic           wr_en;
    logic           wdog_expire;

    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic [AW:0]    count;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (cordic_done)      state_next = enable ? ISSUE : IDLE;
                else if (wdog_expire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cordic_start = (state == ISSUE);
    end

    // A result is only accepted while an operation is outstanding.
    assign push = clk_en && (state == WAIT) && cordic_done;
    assign pop  = clk_en && rd_en && !fifo_empty;

    // ---------------- phase accumulator ----------------
    always_comb begin
        inc_sat = {phase_inc[W-1], phase_inc};
        if (inc_sat > PI_X)       inc_sat = PI_X;
        else if (inc_sat < -PI_X) inc_sat = -PI_X;

        sum = {phase[W-1], phase} + inc_sat;
        if (sum > PI_X)       wrapped = sum - TWO_PI_X;
        else if (sum < -PI_X) wrapped = sum + TWO_PI_X;
        else                  wrapped = sum;
        phase_next = wrapped[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clk_en) begin
            if (load)      phase <= phase_init;
            else if (push) phase <= phase_next;
        end
    end

    assign cordic_theta = phase;

    // ---------------- result FIFO ----------------
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign wr_en      = push && (!fifo_full || pop);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign rd_data    = fifo_empty ? '0 : mem[rd_idx];

    // NOTE: storage has no reset; validity comes entirely from the reset pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= cordic_cos;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_idx <= wr_idx + 1'b1;
            if (pop)   rd_idx <= rd_idx + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clk_en) begin
            if (push && fifo_full && !pop) overflow <= 1'b1;
            else if (ovf_clr)              overflow <= 1'b0;
        end
    end

    // ---------------- optional WAIT watchdog ----------------
`ifdef CORDIC_FEED_TIMEOUT_EN
    logic [5:0] wdog_cnt;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (clk_en) begin
            if (state != WAIT) wdog_cnt <= '0;
            else               wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_expire = (state == WAIT) && !cordic_done && (wdog_cnt == 6'd63);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (clk_en) begin
            if (wdog_expire)  timeout <= 1'b1;
            else if (ovf_clr) timeout <= 1'b0;
        end
    end
`else
    assign wdog_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Directed bench for cordic_phase_feeder: table of phase-wrap vectors plus sweep, FIFO, reset and watchdog sequences.
module tb_cordic_phase_feeder;

    localparam int W = 27;
    localparam logic [W-1:0] PI     = 27'h1921FB5;
    localparam logic [W-1:0] TWO_PI = 27'h3243F6A;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic         enable;
    logic         load;
    logic [W-1:0] phase_init;
    logic [W-1:0] phase_inc;
    logic         cordic_start;
    logic [W-1:0] cordic_theta;
    logic [W-1:0] cordic_cos;
    logic         cordic_done;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         fifo_empty;
    logic         fifo_full;
    logic         overflow;
    logic         ovf_clr;
    logic         timeout;

    int n_checks = 0;
    int n_errors = 0;

    cordic_phase_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .enable       (enable),
        .load         (load),
        .phase_init   (phase_init),
        .phase_inc    (phase_inc),
        .cordic_start (cordic_start),
        .cordic_theta (cordic_theta),
        .cordic_cos   (cordic_cos),
        .cordic_done  (cordic_done),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] init;
        logic [W-1:0] inc;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; cordic_done = 1'b0;
        rd_en = 1'b0; ovf_clr = 1'b0; clk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_start();
        int n = 0;
        while (!cordic_start && n < 16) begin
            step();
            n++;
        end
        check("start_seen", {31'b0, cordic_start}, 32'd1);
    endtask

    // Engine model: answers one cycle after the start pulse.
    task automatic serve(input logic [W-1:0] cos_val, output logic [W-1:0] theta);
        wait_start();
        theta = cordic_theta;
        step();
        check("start_one_cycle", {31'b0, cordic_start}, 32'd0);
        cordic_cos  = cos_val;
        cordic_done = 1'b1;
        step();
        cordic_done = 1'b0;
    endtask

    task automatic load_phase(input logic [W-1:0] p);
        phase_init = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] th;
        logic [W-1:0] sweep_exp [5];

        vecs[0] = '{"plain_step",   27'h0000000, 27'h0800000, 27'h0800000};
        vecs[1] = '{"wrap_pos",     27'h1800000, 27'h0800000, 27'h6DBC096};
        vecs[2] = '{"wrap_neg",     27'h6800000, 27'h7800000, 27'h1243F6A};
        vecs[3] = '{"sat_pos",      27'h1000000, 27'h3000000, 27'h1000000 + PI - TWO_PI};
        vecs[4] = '{"sat_neg",      27'h0000000, 27'h5000000, 27'h66DE04B};
        vecs[5] = '{"exact_pi",     27'h1000000, 27'h0921FB5, 27'h1921FB5};
        vecs[6] = '{"inc_pi_wrap",  27'h0000001, 27'h1921FB5, 27'h66DE04C};

        sweep_exp[0] = 27'h0000000;
        sweep_exp[1] = 27'h0800000;
        sweep_exp[2] = 27'h1000000;
        sweep_exp[3] = 27'h1800000;
        sweep_exp[4] = 27'h6DBC096;

        phase_init = '0; phase_inc = '0; cordic_cos = '0;
        do_reset();

        // Reset state
        check("rst_empty",   {31'b0, fifo_empty},   32'd1);
        check("rst_full",    {31'b0, fifo_full},    32'd0);
        check("rst_rd_data", {5'b0, rd_data},       32'd0);
        check("rst_start",   {31'b0, cordic_start}, 32'd0);
        check("rst_theta",   {5'b0, cordic_theta},  32'd0);
        check("rst_ovf",     {31'b0, overflow},     32'd0);
        check("rst_timeout", {31'b0, timeout},      32'd0);

        // Phase arithmetic table
        for (int i = 0; i < NV; i++) begin
            do_reset();
            load_phase(vecs[i].init);
            phase_inc = vecs[i].inc;
            enable = 1'b1;
            serve(27'h1, th);
            check({vecs[i].name, "_theta0"}, {5'b0, th}, {5'b0, vecs[i].init});
            wait_start();
            check({vecs[i].name, "_next"}, {5'b0, cordic_theta}, {5'b0, vecs[i].exp});
            enable = 1'b0;
        end

        // Sweep with five results into a 4-deep FIFO
        do_reset();
        load_phase(27'h0);
        phase_inc = 27'h0800000;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) enable = 1'b0;
            serve(W'(i + 1), th);
            check("sweep_theta", {5'b0, th}, {5'b0, sweep_exp[i]});
        end
        step();
        check("sweep_idle",  {31'b0, cordic_start}, 32'd0);
        check("ovf_full",    {31'b0, fifo_full},    32'd1);
        check("ovf_set",     {31'b0, overflow},     32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_read", {5'b0, rd_data}, 32'(i + 1));
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        check("ovf_drained", {31'b0, fifo_empty}, 32'd1);
        check("ovf_rd_zero", {5'b0, rd_data},     32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pop_empty_ignored", {31'b0, fifo_empty}, 32'd1);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        load_phase(27'h0);
        phase_inc = 27'h0800000;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) serve(W'(11 + i), th);
        check("pp_full_before", {31'b0, fifo_full}, 32'd1);
        wait_start();
        step();
        cordic_cos = 27'd15; cordic_done = 1'b1; rd_en = 1'b1; enable = 1'b0;
        step();
        cordic_done = 1'b0; rd_en = 1'b0;
        check("pp_full_after", {31'b0, fifo_full}, 32'd1);
        check("pp_no_ovf",     {31'b0, overflow},  32'd0);
        check("pp_head",       {5'b0, rd_data},    32'd12);
        for (int i = 0; i < 4; i++) begin
            check("pp_read", {5'b0, rd_data}, 32'(12 + i));
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        check("pp_empty", {31'b0, fifo_empty}, 32'd1);

        // Stray done, clk_en freeze, load priority over advance
        do_reset();
        cordic_cos = 27'd99; cordic_done = 1'b1;
        step();
        cordic_done = 1'b0;
        check("stray_done_ignored", {31'b0, fifo_empty}, 32'd1);
        load_phase(27'h0);
        phase_inc = 27'h0800000;
        enable = 1'b1;
        wait_start();
        step();
        clk_en = 1'b0; cordic_cos = 27'd33; cordic_done = 1'b1;
        step();
        step();
        check("clk_en_freeze_fifo",  {31'b0, fifo_empty},   32'd1);
        check("clk_en_freeze_start", {31'b0, cordic_start}, 32'd0);
        clk_en = 1'b1; load = 1'b1; phase_init = 27'h0123456;
        step();
        load = 1'b0; cordic_done = 1'b0;
        check("load_push_kept", {5'b0, rd_data}, 32'd33);
        wait_start();
        check("load_priority", {5'b0, cordic_theta}, 32'h0123456);
        enable = 1'b0;

        // Asynchronous reset in WAIT with two queued results
        do_reset();
        load_phase(27'h0);
        phase_inc = 27'h0800000;
        enable = 1'b1;
        serve(27'd7, th);
        serve(27'd8, th);
        step();
        check("pre_rst_head", {5'b0, rd_data}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", {31'b0, fifo_empty},   32'd1);
        check("arst_full",  {31'b0, fifo_full},    32'd0);
        check("arst_rd",    {5'b0, rd_data},       32'd0);
        check("arst_start", {31'b0, cordic_start}, 32'd0);
        check("arst_theta", {5'b0, cordic_theta},  32'd0);
        check("arst_ovf",   {31'b0, overflow},     32'd0);
        step();
        rst_n = 1'b1; enable = 1'b0; cordic_cos = 27'd55; cordic_done = 1'b1;
        step();
        cordic_done = 1'b0;
        check("post_rst_done_ignored", {31'b0, fifo_empty},   32'd1);
        check("post_rst_idle",         {31'b0, cordic_start}, 32'd0);

`ifdef CORDIC_FEED_TIMEOUT_EN
        // Watchdog: engine never answers
        do_reset();
        enable = 1'b1;
        wait_start();
        step();
        enable = 1'b0;
        for (int i = 0; i < 63; i++) step();
        check("wdog_not_yet", {31'b0, timeout}, 32'd0);
        step();
        check("wdog_fired", {31'b0, timeout},    32'd1);
        check("wdog_empty", {31'b0, fifo_empty}, 32'd1);
        step();
        check("wdog_idle",  {31'b0, cordic_start}, 32'd0);
        check("wdog_phase", {5'b0, cordic_theta},  32'd0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("wdog_cleared", {31'b0, timeout}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
